// File: rtl/des_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module      : des_sbox_engine
// Description : DES S-box substitution engine. Takes one 48-bit block
//               (E(R) xor K) and produces the 32-bit S1..S8 result. LANES
//               boxes are looked up per cycle, so one block takes 8/LANES
//               busy cycles plus one result cycle. Sits between the key-mix
//               XOR and the P-permutation of a DES round. Valid/ready on both
//               sides, one block in flight.
//
// Parameters  : LANES  S-box lookups per cycle (1, 2, 4 or 8)
//               CNT_W  width of the wrapping completed-block counter
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   in_data valid
//               in_ready   engine accepts in_data this cycle
//               in_data    [47:42]=S1 input ... [5:0]=S8 input (MSB = DES bit 1)
//               out_valid  out_data valid (held until out_ready)
//               out_ready  downstream takes out_data
//               out_data   [31:28]=S1 output ... [3:0]=S8 output
//               blk_cnt    completed output handshakes, modulo 2^CNT_W
//
// Revision    : 1.0  initial release
// ============================================================================
module des_sbox_engine #(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] blk_cnt
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_num_steps = 8 / LANES;
    localparam int c_step_w    = (c_num_steps > 1) ? $clog2(c_num_steps) : 1;

    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(c_num_steps - 1);
    localparam logic [c_step_w-1:0] c_step_one  = c_step_w'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // ------------------------------------------------------------------------
    // S-box tables. Entry index is {row, col}; entry 0 occupies the most
    // significant nibble, so rows 0..3 read left to right as in FIPS 46-3.
    // ------------------------------------------------------------------------
    localparam logic [255:0] c_s1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] c_s2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] c_s3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] c_s4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] c_s5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] c_s6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] c_s7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] c_s8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    // Combinational lookup of one box: row = {b1,b6}, col = b2..b5.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
        logic [255:0] tbl;
        logic [5:0]   idx;
        case (box)
            3'd0:    tbl = c_s1;
            3'd1:    tbl = c_s2;
            3'd2:    tbl = c_s3;
            3'd3:    tbl = c_s4;
            3'd4:    tbl = c_s5;
            3'd5:    tbl = c_s6;
            3'd6:    tbl = c_s7;
            default: tbl = c_s8;
        endcase
        idx = {grp[5], grp[0], grp[4:1]};
        // Entry idx sits at bit 4*(63-idx) = {~idx, 2'b00}
        return tbl[{~idx, 2'b00} +: 4];
    endfunction

    // ------------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------------
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic                r_alive;     // low during reset and until the first edge after it
    logic [c_step_w-1:0] r_step;
    logic [47:0]         r_in_data;
    logic [31:0]         r_result;
    logic                r_out_valid;
    logic [CNT_W-1:0]    r_blk_cnt;

    // ------------------------------------------------------------------------
    // Lane datapath: lane l handles box step*LANES+l this cycle
    // ------------------------------------------------------------------------
    logic [2:0]  w_box_idx [LANES];
    logic [2:0]  w_box_rev [LANES];   // 7 - box: boxes are numbered from the MSB end
    logic [5:0]  w_grp_lo  [LANES];
    logic [4:0]  w_nib_lo  [LANES];
    logic [3:0]  w_lane_nib[LANES];
    logic [31:0] w_result_nxt;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_box_idx[l]  = 3'(int'(r_step) * LANES + l);
        assign w_box_rev[l]  = ~w_box_idx[l];
        // 6 * rev = 4 * rev + 2 * rev
        assign w_grp_lo[l]   = 6'({w_box_rev[l], 2'b00}) + 6'({w_box_rev[l], 1'b0});
        assign w_nib_lo[l]   = {w_box_rev[l], 2'b00};
        assign w_lane_nib[l] = sbox_lookup(w_box_idx[l], r_in_data[w_grp_lo[l] +: 6]);
    end

    always_comb begin
        w_result_nxt = r_result;
        for (int l = 0; l < LANES; l++) begin
            w_result_nxt[w_nib_lo[l] +: 4] = w_lane_nib[l];
        end
    end

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;

    assign w_in_ready = r_alive & ((r_state == c_st_idle) | ((r_state == c_st_done) & out_ready));
    assign w_in_fire  = w_in_ready & in_valid;
    assign w_out_fire = (r_state == c_st_done) & out_ready;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_alive     <= 1'b0;
            r_step      <= '0;
            r_in_data   <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                c_st_idle: begin
                    if (w_in_fire) begin
                        r_in_data <= in_data;
                        r_step    <= '0;
                        r_state   <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    r_result <= w_result_nxt;
                    if (r_step == c_last_step) begin
                        r_step      <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_step <= r_step + c_step_one;
                    end
                end
                c_st_done: begin
                    if (w_out_fire) begin
                        r_blk_cnt   <= r_blk_cnt + c_cnt_one;
                        r_out_valid <= 1'b0;
                        // A simultaneous input handshake skips the idle bubble
                        if (w_in_fire) begin
                            r_in_data <= in_data;
                            r_step    <= '0;
                            r_state   <= c_st_busy;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_step      <= '0;
                    r_out_valid <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_result;
    assign blk_cnt   = r_blk_cnt;

endmodule
`default_nettype wire
